// File: rtl/pc_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_gen : fetch-stage next-PC select (redirects > RAS pop > stall > +4).   |
// | Optional return-address stack enabled by defining PC_RAS_EN.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              NREDIR    = 2,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                   iClk,
  input  logic                   iRstN,
  input  logic                   iStall,
  input  logic [NREDIR-1:0]      iRedirValid,
  input  logic [NREDIR*XLEN-1:0] iRedirTarget,
  input  logic                   iRasPush,
  input  logic [XLEN-1:0]        iRasPushAddr,
  input  logic                   iRasPop,
  output logic [XLEN-1:0]        oPC,
  output logic                   oMisalign,
  output logic                   oRasEmpty
);

  logic            w_redir_hit;
  logic [XLEN-1:0] w_redir_tgt;
  logic            w_ras_take;
  logic [XLEN-1:0] w_ras_tgt;
  logic [XLEN-1:0] w_raw_tgt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_mis_nxt;
  logic [XLEN-1:0] r_pc;
  logic            r_mis;

  // Scan from the highest index down so the lowest asserted channel wins.
  always_comb begin
    w_redir_hit = 1'b0;
    w_redir_tgt = '0;
    for (int k = NREDIR - 1; k >= 0; k--) begin
      if (iRedirValid[k]) begin
        w_redir_hit = 1'b1;
        w_redir_tgt = iRedirTarget[k*XLEN +: XLEN];
      end
    end
  end

`ifdef PC_RAS_EN
  localparam int              c_PTR_W = $clog2(RAS_DEPTH);
  localparam int              c_CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]    r_ras [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_top;
  logic [c_CNT_W-1:0] r_count;
  logic               w_push;
  logic               w_pop;
  logic [c_PTR_W-1:0] w_top_inc;

  assign w_push     = iRasPush & ~iStall;
  assign w_pop      = iRasPop & ~iStall & (r_count != '0);
  assign w_top_inc  = r_top + c_PTR_W'(1);
  assign w_ras_take = w_pop;
  assign w_ras_tgt  = r_ras[r_top];
  assign oRasEmpty  = (r_count == '0);

  // Push+pop together replaces the top in place, so pointers stay put.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_top <= w_top_inc;
      if (r_count != c_FULL) r_count <= r_count + c_CNT_W'(1);
    end else if (w_pop && !w_push) begin
      r_top   <= r_top - c_PTR_W'(1);
      r_count <= r_count - c_CNT_W'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (w_push) r_ras[w_pop ? r_top : w_top_inc] <= iRasPushAddr;
  end
`else
  logic w_unused_ras;

  assign w_unused_ras = (^{iRasPush, iRasPop, iRasPushAddr}) ^ (RAS_DEPTH == 0);
  assign w_ras_take   = 1'b0;
  assign w_ras_tgt    = '0;
  assign oRasEmpty    = 1'b1;
`endif

  always_comb begin
    w_raw_tgt = w_redir_hit ? w_redir_tgt : w_ras_tgt;
    w_mis_nxt = 1'b0;
    if (w_redir_hit || w_ras_take) begin
      w_pc_nxt  = {w_raw_tgt[XLEN-1:2], 2'b00};
      w_mis_nxt = |w_raw_tgt[1:0];
    end else if (iStall) begin
      w_pc_nxt = r_pc;
    end else begin
      w_pc_nxt = r_pc + XLEN'(4);
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_pc  <= RESET_VEC;
      r_mis <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_mis <= w_mis_nxt;
    end
  end

  assign oPC       = r_pc;
  assign oMisalign = r_mis;

endmodule
`default_nettype wire
